// File: rtl/game_engine_nxn.sv
`default_nettype none
// ============================================================================
// Module   : game_engine_nxn
// Purpose  : N x N K-in-a-row game engine. Holds the board, a wrapping cursor
//            and the turn state. After each placement it runs a fixed-length
//            sequential line scan to detect a win or a draw.
// Revision : 1.0 - initial release
// ============================================================================
module game_engine_nxn #(
    parameter int BOARD_N = 5,
    parameter int WIN_LEN = 4,
    parameter int CW      = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           btn_left,
    input  logic                           btn_right,
    input  logic                           btn_up,
    input  logic                           btn_down,
    input  logic                           place_marker,
    input  logic                           new_game,
    output logic [2*BOARD_N*BOARD_N-1:0]   game_board,
    output logic [CW-1:0]                  cursor_row,
    output logic [CW-1:0]                  cursor_col,
    output logic                           player1_turn,
    output logic                           player2_turn,
    output logic                           game_finished,
    output logic                           last_winner,
    output logic                           draw,
    output logic                           invalid_move,
    output logic                           busy
);

    localparam int OCC_W  = $clog2(BOARD_N*BOARD_N+1);
    localparam int STEP_W = $clog2(WIN_LEN);
    localparam int CNT_W  = $clog2(2*WIN_LEN);
    localparam int PW     = CW + 2;

    localparam logic [CW-1:0]        CENTRE    = CW'(BOARD_N/2);
    localparam logic [CW-1:0]        LAST      = CW'(BOARD_N-1);
    localparam logic [OCC_W-1:0]     FULL      = OCC_W'(BOARD_N*BOARD_N);
    localparam logic [STEP_W-1:0]    LAST_STEP = STEP_W'(WIN_LEN-2);
    localparam logic [CNT_W-1:0]     WIN_CNT   = CNT_W'(WIN_LEN);
    localparam logic signed [PW-1:0] N_S       = PW'(BOARD_N);

    // Event vector bit positions, highest index = highest priority
    localparam int EV_NEW   = 5;
    localparam int EV_PLACE = 4;
    localparam int EV_UP    = 3;
    localparam int EV_DOWN  = 2;
    localparam int EV_LEFT  = 1;
    localparam int EV_RIGHT = 0;

    typedef enum logic [1:0] {S_PLAY, S_CHECK, S_EVAL, S_OVER} state_t;

    logic [5:0] btn;
    logic [5:0] prev_q;
    logic [5:0] ev_q;

    state_t               state_q, state_d;
    logic [1:0]           cells_q [BOARD_N][BOARD_N];
    logic [1:0]           cells_d [BOARD_N][BOARD_N];
    logic [CW-1:0]        row_q, row_d, col_q, col_d;
    logic                 turn_q, turn_d, starter_q, starter_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic                 lw_q, lw_d, draw_q, draw_d;
    logic                 gf_q, gf_d, inv_q, inv_d;
    logic [1:0]           dir_q, dir_d;
    logic                 neg_q, neg_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic signed [PW-1:0] pr_q, pr_d, pc_q, pc_d;
    logic                 frz_q, frz_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 win_q, win_d;

    logic [1:0]           mover;
    logic signed [PW-1:0] dr, dc, cand_r, cand_c;
    logic                 inb, hit;
    logic [1:0]           scan_cell;
    logic [CNT_W-1:0]     cnt_n;

    assign btn = {new_game, place_marker, btn_up, btn_down, btn_left, btn_right};

    // Rising-edge detection; held levels at reset produce no event
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= btn;
            ev_q   <= '0;
        end else begin
            prev_q <= btn;
            ev_q   <= btn & ~prev_q;
        end
    end

    // Next-state logic: play control, line scanner and evaluation
    always_comb begin
        state_d   = state_q;
        cells_d   = cells_q;
        row_d     = row_q;
        col_d     = col_q;
        turn_d    = turn_q;
        starter_d = starter_q;
        occ_d     = occ_q;
        lw_d      = lw_q;
        draw_d    = draw_q;
        gf_d      = 1'b0;
        inv_d     = 1'b0;
        dir_d     = dir_q;
        neg_d     = neg_q;
        step_d    = step_q;
        pr_d      = pr_q;
        pc_d      = pc_q;
        frz_d     = frz_q;
        cnt_d     = cnt_q;
        win_d     = win_q;

        mover = turn_q ? 2'b10 : 2'b01;

        // Step vector for the current direction; negative half flips it
        case (dir_q)
            2'd0:    begin dr = '0;         dc = PW'(1);      end
            2'd1:    begin dr = PW'(1);     dc = '0;          end
            2'd2:    begin dr = PW'(1);     dc = PW'(1);      end
            default: begin dr = PW'(1);     dc = {PW{1'b1}};  end
        endcase
        if (neg_q) begin
            dr = -dr;
            dc = -dc;
        end
        cand_r    = pr_q + dr;
        cand_c    = pc_q + dc;
        inb       = !cand_r[PW-1] && (cand_r < N_S) && !cand_c[PW-1] && (cand_c < N_S);
        scan_cell = cells_q[cand_r[CW-1:0]][cand_c[CW-1:0]];
        hit       = !frz_q && inb && (scan_cell == mover);
        cnt_n     = cnt_q + {{(CNT_W-1){1'b0}}, hit};

        case (state_q)
            S_PLAY: begin
                if (ev_q[EV_PLACE]) begin
                    if (cells_q[row_q][col_q] == 2'b00) begin
                        cells_d[row_q][col_q] = mover;
                        occ_d   = occ_q + OCC_W'(1);
                        state_d = S_CHECK;
                        dir_d   = 2'd0;
                        neg_d   = 1'b0;
                        step_d  = '0;
                        pr_d    = $signed({2'b00, row_q});
                        pc_d    = $signed({2'b00, col_q});
                        frz_d   = 1'b0;
                        cnt_d   = CNT_W'(1);
                        win_d   = 1'b0;
                    end else begin
                        inv_d = 1'b1;
                    end
                end else if (ev_q[EV_UP]) begin
                    row_d = (row_q == '0) ? LAST : row_q - CW'(1);
                end else if (ev_q[EV_DOWN]) begin
                    row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
                end else if (ev_q[EV_LEFT]) begin
                    col_d = (col_q == '0) ? LAST : col_q - CW'(1);
                end else if (ev_q[EV_RIGHT]) begin
                    col_d = (col_q == LAST) ? '0 : col_q + CW'(1);
                end
            end
            S_CHECK: begin
                // A miss or board edge freezes the remainder of this half
                if (hit) begin
                    pr_d = cand_r;
                    pc_d = cand_c;
                end
                frz_d = frz_q | ~hit;
                cnt_d = cnt_n;
                if (step_q == LAST_STEP) begin
                    step_d = '0;
                    frz_d  = 1'b0;
                    pr_d   = $signed({2'b00, row_q});
                    pc_d   = $signed({2'b00, col_q});
                    if (!neg_q) begin
                        neg_d = 1'b1;
                    end else begin
                        neg_d = 1'b0;
                        cnt_d = CNT_W'(1);
                        win_d = win_q | (cnt_n >= WIN_CNT);
                        dir_d = dir_q + 2'd1;
                        if (dir_q == 2'd3) begin
                            state_d = S_EVAL;
                        end
                    end
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            S_EVAL: begin
                if (win_q) begin
                    gf_d    = 1'b1;
                    lw_d    = turn_q;
                    state_d = S_OVER;
                end else if (occ_q == FULL) begin
                    gf_d    = 1'b1;
                    draw_d  = 1'b1;
                    state_d = S_OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = S_PLAY;
                end
            end
            default: begin
            end
        endcase

        // New game overrides everything, including a scan in progress
        if (ev_q[EV_NEW]) begin
            cells_d   = '{default: '{default: 2'b00}};
            occ_d     = '0;
            draw_d    = 1'b0;
            gf_d      = 1'b0;
            inv_d     = 1'b0;
            row_d     = CENTRE;
            col_d     = CENTRE;
            starter_d = ~starter_q;
            turn_d    = ~starter_q;
            state_d   = S_PLAY;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_PLAY;
            cells_q   <= '{default: '{default: 2'b00}};
            row_q     <= CENTRE;
            col_q     <= CENTRE;
            turn_q    <= 1'b0;
            starter_q <= 1'b0;
            occ_q     <= '0;
            lw_q      <= 1'b0;
            draw_q    <= 1'b0;
            gf_q      <= 1'b0;
            inv_q     <= 1'b0;
            dir_q     <= '0;
            neg_q     <= 1'b0;
            step_q    <= '0;
            pr_q      <= '0;
            pc_q      <= '0;
            frz_q     <= 1'b0;
            cnt_q     <= '0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cells_q   <= cells_d;
            row_q     <= row_d;
            col_q     <= col_d;
            turn_q    <= turn_d;
            starter_q <= starter_d;
            occ_q     <= occ_d;
            lw_q      <= lw_d;
            draw_q    <= draw_d;
            gf_q      <= gf_d;
            inv_q     <= inv_d;
            dir_q     <= dir_d;
            neg_q     <= neg_d;
            step_q    <= step_d;
            pr_q      <= pr_d;
            pc_q      <= pc_d;
            frz_q     <= frz_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
        end
    end

    // Flatten the board for the display
    for (genvar r = 0; r < BOARD_N; r++) begin : g_row
        for (genvar c = 0; c < BOARD_N; c++) begin : g_col
            assign game_board[2*(r*BOARD_N+c) +: 2] = cells_q[r][c];
        end
    end

    assign cursor_row    = row_q;
    assign cursor_col    = col_q;
    assign player1_turn  = (state_q != S_OVER) && !turn_q;
    assign player2_turn  = (state_q != S_OVER) &&  turn_q;
    assign game_finished = gf_q;
    assign last_winner   = lw_q;
    assign draw          = draw_q;
    assign invalid_move  = inv_q;
    assign busy          = (state_q == S_CHECK);

endmodule
`default_nettype wire

// File: tb/tb_game_engine_nxn.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_engine_nxn
// Purpose  : Directed self-checking bench for game_engine_nxn (5x5/K=4 and
//            3x3/K=3 instances sharing one set of button inputs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_engine_nxn;

    localparam int EV_NEW   = 5;
    localparam int EV_PLACE = 4;
    localparam int EV_UP    = 3;
    localparam int EV_DOWN  = 2;
    localparam int EV_LEFT  = 1;
    localparam int EV_RIGHT = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  btn;

    logic [49:0] board5;
    logic [2:0]  row5, col5;
    logic        p1_5, p2_5, gf5, lw5, draw5, inv5, busy5;

    logic [17:0] board3;
    logic [1:0]  row3, col3;
    logic        p1_3, p2_3, gf3, lw3, draw3, inv3, busy3;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          nb      = 5;
    int          cr, cc;
    logic [63:0] exp_b;
    int          gf_seen;

    always #5 clk = ~clk;

    game_engine_nxn u_dut5 (
        .clk(clk), .rst(rst),
        .btn_left(btn[EV_LEFT]), .btn_right(btn[EV_RIGHT]),
        .btn_up(btn[EV_UP]), .btn_down(btn[EV_DOWN]),
        .place_marker(btn[EV_PLACE]), .new_game(btn[EV_NEW]),
        .game_board(board5), .cursor_row(row5), .cursor_col(col5),
        .player1_turn(p1_5), .player2_turn(p2_5), .game_finished(gf5),
        .last_winner(lw5), .draw(draw5), .invalid_move(inv5), .busy(busy5)
    );

    game_engine_nxn #(.BOARD_N(3), .WIN_LEN(3), .CW(2)) u_dut3 (
        .clk(clk), .rst(rst),
        .btn_left(btn[EV_LEFT]), .btn_right(btn[EV_RIGHT]),
        .btn_up(btn[EV_UP]), .btn_down(btn[EV_DOWN]),
        .place_marker(btn[EV_PLACE]), .new_game(btn[EV_NEW]),
        .game_board(board3), .cursor_row(row3), .cursor_col(col3),
        .player1_turn(p1_3), .player2_turn(p2_3), .game_finished(gf3),
        .last_winner(lw3), .draw(draw3), .invalid_move(inv3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        tick();
        btn[b] = 1'b0;
        tick();
    endtask

    task automatic do_reset(input int n);
        nb    = n;
        rst   = 1'b1;
        btn   = '0;
        tick();
        tick();
        rst   = 1'b0;
        tick();
        cr    = n / 2;
        cc    = n / 2;
        exp_b = '0;
    endtask

    task automatic goto(input int r, input int c);
        while (cr < r) begin press(EV_DOWN);  cr++; end
        while (cr > r) begin press(EV_UP);    cr--; end
        while (cc < c) begin press(EV_RIGHT); cc++; end
        while (cc > c) begin press(EV_LEFT);  cc--; end
    endtask

    task automatic mark(input int r, input int c, input logic [1:0] code);
        exp_b[2*(r*nb+c) +: 2] = code;
    endtask

    // Non-final placement: wait through scan and evaluation back to play
    task automatic place_play(input int r, input int c, input logic [1:0] code);
        goto(r, c);
        press(EV_PLACE);
        mark(r, c, code);
        repeat (8*((nb == 5) ? 3 : 2) + 1) tick();
    endtask

    initial begin
        rst = 1'b1;
        btn = '0;
        exp_b = '0;

        // ---------------- reset state and cursor wrap ----------------
        do_reset(5);
        chk("rst_row", 64'(row5), 64'd2);
        chk("rst_col", 64'(col5), 64'd2);
        chk("rst_board", 64'(board5), 64'd0);
        chk("rst_p1", 64'(p1_5), 64'd1);
        chk("rst_p2", 64'(p2_5), 64'd0);
        chk("rst_flags", 64'({gf5, lw5, draw5, inv5, busy5}), 64'd0);
        press(EV_UP); chk("up1_row", 64'(row5), 64'd1);
        press(EV_UP); chk("up2_row", 64'(row5), 64'd0);
        press(EV_UP); chk("up3_row_wrap", 64'(row5), 64'd4);
        press(EV_UP); chk("up4_row", 64'(row5), 64'd3);
        press(EV_UP); chk("up5_row", 64'(row5), 64'd2);
        chk("up_col", 64'(col5), 64'd2);
        chk("up_board", 64'(board5), 64'd0);
        chk("up_p1", 64'(p1_5), 64'd1);

        // ---------------- P1 horizontal win on row 0 ----------------
        place_play(0, 0, 2'b01);
        chk("h_board1", 64'(board5), exp_b);
        chk("h_p2turn", 64'(p2_5), 64'd1);
        place_play(4, 0, 2'b10);
        place_play(0, 1, 2'b01);
        place_play(4, 1, 2'b10);
        place_play(0, 2, 2'b01);
        place_play(4, 2, 2'b10);
        chk("h_board6", 64'(board5), exp_b);
        chk("h_p1turn", 64'(p1_5), 64'd1);
        goto(0, 3);
        press(EV_PLACE);
        mark(0, 3, 2'b01);
        chk("h_busy", 64'(busy5), 64'd1);
        repeat (24) tick();
        chk("h_gf_early", 64'(gf5), 64'd0);
        tick();
        chk("h_gf", 64'(gf5), 64'd1);
        chk("h_lw", 64'(lw5), 64'd0);
        chk("h_draw", 64'(draw5), 64'd0);
        chk("h_leds", 64'({p1_5, p2_5}), 64'd0);
        tick();
        chk("h_gf_pulse", 64'(gf5), 64'd0);
        press(EV_RIGHT);
        press(EV_PLACE);
        chk("over_col", 64'(col5), 64'd3);
        chk("over_board", 64'(board5), exp_b);

        // ---------------- invalid move on occupied cell ----------------
        do_reset(5);
        place_play(1, 1, 2'b01);
        press(EV_PLACE);
        chk("inv_pulse", 64'(inv5), 64'd1);
        chk("inv_board", 64'(board5), exp_b);
        chk("inv_p2turn", 64'(p2_5), 64'd1);
        chk("inv_busy", 64'(busy5), 64'd0);
        tick();
        chk("inv_pulse_end", 64'(inv5), 64'd0);

        // ---------------- P2 anti-diagonal win ----------------
        place_play(0, 3, 2'b10);
        place_play(4, 4, 2'b01);
        place_play(2, 1, 2'b10);
        place_play(4, 3, 2'b01);
        place_play(3, 0, 2'b10);
        place_play(4, 1, 2'b01);
        goto(1, 2);
        press(EV_PLACE);
        mark(1, 2, 2'b10);
        repeat (24) tick();
        chk("a_gf_early", 64'(gf5), 64'd0);
        tick();
        chk("a_gf", 64'(gf5), 64'd1);
        chk("a_lw", 64'(lw5), 64'd1);
        chk("a_board", 64'(board5), exp_b);

        // ---------------- new game, including abort mid-scan ----------------
        press(EV_NEW);
        cr = 2; cc = 2; exp_b = '0;
        chk("ng_board", 64'(board5), 64'd0);
        chk("ng_p2turn", 64'(p2_5), 64'd1);
        chk("ng_lw_kept", 64'(lw5), 64'd1);
        chk("ng_cursor", 64'({row5, col5}), 64'({3'd2, 3'd2}));
        press(EV_NEW);
        chk("ng2_p1turn", 64'(p1_5), 64'd1);
        press(EV_PLACE);
        repeat (4) tick();
        chk("abort_busy_before", 64'(busy5), 64'd1);
        press(EV_NEW);
        chk("abort_board", 64'(board5), 64'd0);
        chk("abort_busy", 64'(busy5), 64'd0);
        chk("abort_p2turn", 64'(p2_5), 64'd1);
        chk("abort_lw", 64'(lw5), 64'd1);
        gf_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gf5) gf_seen++;
        end
        chk("abort_no_gf", 64'(gf_seen), 64'd0);
        press(EV_PLACE);
        mark(2, 2, 2'b10);
        chk("abort_then_place", 64'(board5), exp_b);

        // ---------------- 3x3 K=3 draw ----------------
        do_reset(3);
        place_play(0, 0, 2'b01);
        place_play(0, 1, 2'b10);
        place_play(0, 2, 2'b01);
        place_play(1, 1, 2'b10);
        place_play(1, 0, 2'b01);
        place_play(1, 2, 2'b10);
        place_play(2, 1, 2'b01);
        place_play(2, 0, 2'b10);
        chk("d_board8", 64'(board3), exp_b);
        goto(2, 2);
        press(EV_PLACE);
        mark(2, 2, 2'b01);
        repeat (16) tick();
        chk("d_gf_early", 64'(gf3), 64'd0);
        tick();
        chk("d_gf", 64'(gf3), 64'd1);
        chk("d_draw", 64'(draw3), 64'd1);
        chk("d_leds", 64'({p1_3, p2_3}), 64'd0);
        chk("d_lw", 64'(lw3), 64'd0);
        chk("d_board", 64'(board3), exp_b);
        tick();
        chk("d_gf_pulse", 64'(gf3), 64'd0);
        chk("d_draw_held", 64'(draw3), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_engine_nxn.md
Name: game_engine_nxn

Overview:
- Parametrised successor to the fixed 5x5 game manager.
- Holds an N x N board, a wrapping cursor and turn state, and detects K-in-a-row wins and draws with a deterministic sequential line scanner.
- Sits between the debounced button inputs and the match manager / VGA display.
- Reports game_finished, last_winner and draw to the match manager.

Parameters:
- BOARD_N, 5, board side length (3..8).
- WIN_LEN, 4, consecutive markers needed to win (2..BOARD_N).
- CW, 3, cursor coordinate width; must satisfy 2^CW >= BOARD_N.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- btn_left  input  1  debounced level; edge-detected internally.
- btn_right  input  1  debounced level; edge-detected internally.
- btn_up  input  1  debounced level; edge-detected internally.
- btn_down  input  1  debounced level; edge-detected internally.
- place_marker  input  1  debounced level; rising edge places a marker.
- new_game  input  1  debounced level; rising edge clears the board, keeps scores/last_winner.
- game_board  output  2*BOARD_N*BOARD_N  cell (r,c) at bits [2*(r*N+c)+1 : 2*(r*N+c)]; 00 empty, 01 P1, 10 P2.
- cursor_row  output  CW  cursor row.
- cursor_col  output  CW  cursor column.
- player1_turn  output  1  LED; high when P1 to move.
- player2_turn  output  1  LED; high when P2 to move.
- game_finished  output  1  one-cycle pulse on win or draw.
- last_winner  output  1  0 = P1, 1 = P2; valid when game_finished pulses with draw=0.
- draw  output  1  set with game_finished on full board without a win; held until new game.
- invalid_move  output  1  one-cycle pulse when placing on an occupied cell.
- busy  output  1  high during CHECK.

Behaviour:
- Reset (sync, rst=1 at edge):
  - board all 00; cursor (N/2, N/2), i.e. (2,2) for N=5.
  - player1_turn=1, player2_turn=0; starter=P1.
  - last_winner=0; draw=0; game_finished=0; invalid_move=0; busy=0.
  - occupied count=0; state=PLAY; edge-detect registers loaded with current input levels, so held buttons give no event.
- Edge detect: event = input & ~prev, registered each cycle. At most one event acted on per cycle; priority new_game > place > up > down > left > right. Lower-priority events in the same cycle are dropped.
- States:
  - PLAY
    - Cursor moves with wrap-around: up from row 0 goes to N-1; right from col N-1 goes to 0.
    - Place on an empty cell: write the current player's code at the next edge, occupied++, go to CHECK.
    - Place on an occupied cell: invalid_move pulses, no other change.
  - CHECK (busy=1)
    - Scan directions in fixed order: horizontal, vertical, diagonal (+1,+1), anti-diagonal (+1,-1).
    - Each direction takes exactly 2*(WIN_LEN-1) cycles: WIN_LEN-1 steps positive, then WIN_LEN-1 steps negative, starting from the placed cell.
    - count starts at 1 per direction and increments while the stepped cell is in-board and matches; the first edge or mismatch freezes that half.
    - Cycle count is fixed regardless of matches.
    - All button/place events are ignored; new_game is honoured.
  - EVAL (1 cycle)
    - Any direction count >= WIN_LEN: game_finished=1, last_winner=mover, go to OVER.
    - Else if occupied == N*N: game_finished=1, draw=1, go to OVER.
    - Else toggle turn, go to PLAY.
  - Latency: game_finished asserted exactly 8*(WIN_LEN-1)+2 cycles after the cycle in which the place event is acted on (26 for WIN_LEN=4).
  - OVER: board frozen; turn LEDs both 0; only new_game or rst leave this state.
- new_game event (any state, including mid-CHECK):
  - Clears board, occupied, draw; aborts any scan with no game_finished.
  - Cursor returns to centre; starter toggles and the new game begins with that player.
  - last_winner is retained. State goes to PLAY at the next cycle.
- rst has priority over everything.
- occupied is a counter wide enough for N*N (clog2(N*N+1) bits); no wrap possible because placement is blocked on full cells.

Test Plan:
- Reset, then 5 up pulses -> cursor_row sequence 1,0,4,3,2; cursor_col stays 2; board all zero; player1_turn=1.
- N=5, K=4, P1 places (0,0),(0,1),(0,2),(0,3), P2 places elsewhere between them -> game_finished pulses 26 cycles after P1's 4th place with last_winner=0, draw=0; later buttons change nothing.
- P1 at (1,1), P2 places on (1,1) -> invalid_move pulse, cell stays 01, player2_turn stays 1.
- Anti-diagonal win for P2 at (0,3),(1,2),(2,1),(3,0), last placed in the middle -> win detected with last_winner=1.
- N=3, K=3, fill the board with no line -> 9th place gives game_finished with draw=1, both turn LEDs 0.
- new_game pulsed 5 cycles into CHECK -> no game_finished, board cleared, player2_turn=1 (starter toggled), last_winner unchanged.
